// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one difference bit per clock, LSB first,
// with valid/ready handshakes on operand input and result output.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             BIN,
  input  logic             VALID_IN,
  output logic             READY_OUT,
  output logic [WIDTH-1:0] O,
  output logic             BOUT,
  output logic             VALID_OUT,
  input  logic             READY_IN
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             valid_q, valid_d;

  logic             diff_bit;
  logic             borrow_nxt;
  logic [WIDTH-1:0] acc_shifted;

  // Single subtract cell on the current LSBs and the registered borrow.
  always_comb begin
    diff_bit    = a_q[0] ^ b_q[0] ^ br_q;
    borrow_nxt  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    acc_shifted = {diff_bit, acc_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    o_d     = o_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    valid_d = valid_q;

    case (state_q)
      IDLE: begin
        if (VALID_IN) begin
          a_d     = I0;
          b_d     = I1;
          br_d    = BIN;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = acc_shifted;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = borrow_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          o_d     = acc_shifted;
          bout_d  = borrow_nxt;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (READY_IN) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      o_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      o_q     <= o_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      valid_q <= valid_d;
    end
  end

  // Ready is combinational so it drops immediately while reset is asserted.
  assign READY_OUT = (state_q == IDLE) & ~RESET;
  assign O         = o_q;
  assign BOUT      = bout_q;
  assign VALID_OUT = valid_q;

endmodule
